// File: rtl/ram_job_dispatcher.sv
// Issues a batch of num_jobs jobs to read_write_ram over start/ready/done and reports completion.
// Optional per-job watchdog compiled in with `define DISPATCH_TIMEOUT_EN.
module ram_job_dispatcher #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [CNT_W-1:0] num_jobs,
    output logic             busy,
    output logic             finished,
    output logic [CNT_W-1:0] jobs_done,
    output logic             timeout_err,
    output logic             start,
    input  logic             ready,
    input  logic             done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] target, target_n;
    logic [CNT_W-1:0] jobs_n, jobs_inc;
    logic             busy_n, finished_n, start_n;

    assign jobs_inc = jobs_done + CNT_W'(1);

`ifdef DISPATCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog, wdog_n;
    logic            terr, terr_n;
    assign timeout_err = terr;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            target    <= '0;
            jobs_done <= '0;
            busy      <= 1'b0;
            finished  <= 1'b0;
            start     <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            wdog      <= '0;
            terr      <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            target    <= target_n;
            jobs_done <= jobs_n;
            busy      <= busy_n;
            finished  <= finished_n;
            start     <= start_n;
`ifdef DISPATCH_TIMEOUT_EN
            wdog      <= wdog_n;
            terr      <= terr_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        target_n   = target;
        jobs_n     = jobs_done;
        busy_n     = busy;
        finished_n = 1'b0;
        start_n    = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
        wdog_n     = wdog;
        terr_n     = terr;
`endif
        case (state)
            IDLE: begin
                if (go) begin
                    jobs_n = '0;
`ifdef DISPATCH_TIMEOUT_EN
                    terr_n = 1'b0;
`endif
                    if (num_jobs != '0) begin
                        target_n = num_jobs;
                        busy_n   = 1'b1;
                        state_n  = ISSUE;
                    end else begin
                        // Empty batch completes immediately without touching downstream
                        finished_n = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (ready) begin
                    start_n = 1'b1;
`ifdef DISPATCH_TIMEOUT_EN
                    wdog_n  = '0;
`endif
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (done) begin
                    jobs_n = jobs_inc;
                    if (jobs_inc == target) begin
                        busy_n     = 1'b0;
                        finished_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        state_n = ISSUE;
                    end
                end
`ifdef DISPATCH_TIMEOUT_EN
                // wdog counts WAIT cycles already spent; this is the last allowed one
                else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    terr_n     = 1'b1;
                    busy_n     = 1'b0;
                    finished_n = 1'b1;
                    state_n    = IDLE;
                end else begin
                    wdog_n = wdog + WD_W'(1);
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
